// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: round-robin two-requester sequencer for the register file's single access port.
// All outputs are registered from the next state so strobes, grants and acks line up with the FSM cycles.
module rf_access_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter bit REG0_PROTECT = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  A_REQ,
    input  logic                  B_REQ,
    input  logic                  A_WE,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] A_ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] B_ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] B_ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] A_ADDR_W,
    input  logic [ADDR_WIDTH-1:0] B_ADDR_W,
    input  logic [DATA_WIDTH-1:0] A_WDATA,
    input  logic [DATA_WIDTH-1:0] B_WDATA,
    output logic                  A_ACK,
    output logic                  B_ACK,
    output logic                  A_GNT,
    output logic                  B_GNT,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic [DATA_WIDTH-1:0] RDATA2,
    output logic                  BUSY,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0] RF_DATA_W,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
    state_t                state, state_n;
    logic                  ptr_b, owner_b, we_q;
    logic                  pick_b, lat, own_n, we_n;
    logic [ADDR_WIDTH-1:0] addr_w_n;
    always_comb begin
        pick_b   = B_REQ && (!A_REQ || ptr_b);
        lat      = (state == IDLE) && (A_REQ || B_REQ);
        own_n    = lat ? pick_b : owner_b;
        we_n     = lat ? (pick_b ? B_WE : A_WE) : we_q;
        addr_w_n = lat ? (pick_b ? B_ADDR_W : A_ADDR_W) : RF_ADDR_W;
        state_n  = state == IDLE    ? (lat ? ISSUE : IDLE) :
                   state == ISSUE   ? (we_q ? DONE : CAPTURE) :
                   state == CAPTURE ? DONE : IDLE;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_b      <= 1'b0;
            owner_b    <= 1'b0;
            we_q       <= 1'b0;
            A_ACK      <= 1'b0;
            B_ACK      <= 1'b0;
            A_GNT      <= 1'b0;
            B_GNT      <= 1'b0;
            BUSY       <= 1'b0;
            RF_READ    <= 1'b0;
            RF_WRITE   <= 1'b0;
            RDATA1     <= '0;
            RDATA2     <= '0;
            RF_ADDR_R1 <= '0;
            RF_ADDR_R2 <= '0;
            RF_ADDR_W  <= '0;
            RF_DATA_W  <= '0;
        end else begin
            owner_b  <= own_n;
            we_q     <= we_n;
            BUSY     <= state_n != IDLE;
            A_GNT    <= state_n != IDLE && !own_n;
            B_GNT    <= state_n != IDLE && own_n;
            A_ACK    <= state_n == DONE && !own_n;
            B_ACK    <= state_n == DONE && own_n;
            RF_READ  <= (state_n == ISSUE && !we_n) || state_n == CAPTURE;
            // A protected write to R0 still runs the sequence, just without the strobe
            RF_WRITE <= state_n == ISSUE && we_n && !(REG0_PROTECT && addr_w_n == '0);
            RF_ADDR_W <= addr_w_n;
            if (lat) begin
                RF_ADDR_R1 <= pick_b ? B_ADDR_R1 : A_ADDR_R1;
                RF_ADDR_R2 <= pick_b ? B_ADDR_R2 : A_ADDR_R2;
                RF_DATA_W  <= pick_b ? B_WDATA : A_WDATA;
            end
            if (state == CAPTURE) begin
                RDATA1 <= RF_DATA_R1;
                RDATA2 <= RF_DATA_R2;
            end
            if (state == DONE) ptr_b <= !owner_b;
        end
    end
endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb_rf_access_arbiter: directed bench with a behavioural 32x32 register file on the RF port.
module tb_rf_access_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        A_REQ = 0, B_REQ = 0, A_WE = 0, B_WE = 0;
    logic [4:0]  A_ADDR_R1 = 0, A_ADDR_R2 = 0, B_ADDR_R1 = 0, B_ADDR_R2 = 0, A_ADDR_W = 0, B_ADDR_W = 0;
    logic [31:0] A_WDATA = 0, B_WDATA = 0;
    logic        A_ACK, B_ACK, A_GNT, B_GNT, BUSY, RF_READ, RF_WRITE;
    logic [31:0] RDATA1, RDATA2, RF_DATA_W, RF_DATA_R1, RF_DATA_R2;
    logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
    logic [31:0] mem [32] = '{default: 32'h0};
    logic [154:0] outs;
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) if (RF_WRITE) mem[RF_ADDR_W] <= RF_DATA_W;
    assign RF_DATA_R1 = mem[RF_ADDR_R1];
    assign RF_DATA_R2 = mem[RF_ADDR_R2];
    assign outs = {A_ACK, B_ACK, A_GNT, B_GNT, BUSY, RF_READ, RF_WRITE, RDATA1, RDATA2,
                   RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W};

    rf_access_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG0_PROTECT(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .B_REQ(B_REQ), .A_WE(A_WE), .B_WE(B_WE),
        .A_ADDR_R1(A_ADDR_R1), .A_ADDR_R2(A_ADDR_R2), .B_ADDR_R1(B_ADDR_R1), .B_ADDR_R2(B_ADDR_R2),
        .A_ADDR_W(A_ADDR_W), .B_ADDR_W(B_ADDR_W), .A_WDATA(A_WDATA), .B_WDATA(B_WDATA),
        .A_ACK(A_ACK), .B_ACK(B_ACK), .A_GNT(A_GNT), .B_GNT(B_GNT),
        .RDATA1(RDATA1), .RDATA2(RDATA2), .BUSY(BUSY),
        .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
        .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
        .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2)
    );

    // Every cycle advance also checks that the two strobes never overlap
    task tick;
        @(negedge CLK);
        total++; if (RF_READ && RF_WRITE) begin bad++; $display("FAIL strobe_overlap: rd=%b wr=%b want not both 1", RF_READ, RF_WRITE); end
    endtask

    task reset_pulse;
        RST = 1'b1;
        tick;
        RST = 1'b0;
        tick;
    endtask

    task test_reset;
        tick;
        tick;
        total++; if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
        RST = 1'b0;
        tick;
        total++; if (outs !== '0) begin bad++; $display("FAIL idle_after_reset: got %h want 0", outs); end
    endtask

    task test_single_write;
        A_REQ = 1; A_WE = 1; A_ADDR_W = 5'd5; A_WDATA = 32'hDEADBEEF;
        tick;
        total++; if (RF_WRITE !== 1'b1) begin bad++; $display("FAIL wr_issue_strobe: got %b want 1", RF_WRITE); end
        total++; if (RF_ADDR_W !== 5'd5) begin bad++; $display("FAIL wr_addr: got %0d want 5", RF_ADDR_W); end
        total++; if (RF_DATA_W !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data: got %h want deadbeef", RF_DATA_W); end
        total++; if ({A_GNT, B_GNT, BUSY, A_ACK} !== 4'b1010) begin bad++; $display("FAIL wr_issue_ctl: got %b want 1010", {A_GNT, B_GNT, BUSY, A_ACK}); end
        tick;
        total++; if ({RF_WRITE, A_ACK, B_ACK, A_GNT} !== 4'b0101) begin bad++; $display("FAIL wr_done: got %b want 0101", {RF_WRITE, A_ACK, B_ACK, A_GNT}); end
        A_REQ = 0;
        tick;
        total++; if ({A_ACK, BUSY, A_GNT, RF_WRITE} !== 4'b0000) begin bad++; $display("FAIL wr_idle: got %b want 0000", {A_ACK, BUSY, A_GNT, RF_WRITE}); end
        total++; if (RF_ADDR_W !== 5'd5) begin bad++; $display("FAIL wr_addr_hold: got %0d want 5", RF_ADDR_W); end
    endtask

    task test_single_read;
        A_REQ = 1; A_WE = 0; A_ADDR_R1 = 5'd5; A_ADDR_R2 = 5'd0;
        tick;
        total++; if ({RF_READ, RF_WRITE, A_ACK} !== 3'b100) begin bad++; $display("FAIL rd_issue: got %b want 100", {RF_READ, RF_WRITE, A_ACK}); end
        tick;
        total++; if ({RF_READ, A_ACK, BUSY} !== 3'b101) begin bad++; $display("FAIL rd_capture: got %b want 101", {RF_READ, A_ACK, BUSY}); end
        tick;
        total++; if ({RF_READ, A_ACK} !== 2'b01) begin bad++; $display("FAIL rd_done: got %b want 01", {RF_READ, A_ACK}); end
        total++; if (RDATA1 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data1: got %h want deadbeef", RDATA1); end
        total++; if (RDATA2 !== 32'h0) begin bad++; $display("FAIL rd_data2: got %h want 0", RDATA2); end
        A_REQ = 0;
        tick;
        total++; if ({A_ACK, BUSY} !== 2'b00) begin bad++; $display("FAIL rd_idle: got %b want 00", {A_ACK, BUSY}); end
    endtask

    task test_simultaneous;
        reset_pulse;
        A_REQ = 1; A_WE = 1; A_ADDR_W = 5'd1; A_WDATA = 32'h11;
        B_REQ = 1; B_WE = 1; B_ADDR_W = 5'd2; B_WDATA = 32'h22;
        tick;
        total++; if ({A_GNT, B_GNT} !== 2'b10) begin bad++; $display("FAIL sim_first_gnt: got %b want 10", {A_GNT, B_GNT}); end
        total++; if (RF_ADDR_W !== 5'd1) begin bad++; $display("FAIL sim_first_addr: got %0d want 1", RF_ADDR_W); end
        tick;
        total++; if ({A_ACK, B_ACK} !== 2'b10) begin bad++; $display("FAIL sim_a_ack: got %b want 10", {A_ACK, B_ACK}); end
        A_REQ = 0;
        tick;
        total++; if ({B_ACK, BUSY} !== 2'b00) begin bad++; $display("FAIL sim_gap: got %b want 00", {B_ACK, BUSY}); end
        tick;
        total++; if ({A_GNT, B_GNT, RF_WRITE} !== 3'b011) begin bad++; $display("FAIL sim_b_issue: got %b want 011", {A_GNT, B_GNT, RF_WRITE}); end
        total++; if (RF_ADDR_W !== 5'd2) begin bad++; $display("FAIL sim_b_addr: got %0d want 2", RF_ADDR_W); end
        tick;
        total++; if ({A_ACK, B_ACK} !== 2'b01) begin bad++; $display("FAIL sim_b_ack: got %b want 01", {A_ACK, B_ACK}); end
        B_REQ = 0;
        tick;
        A_REQ = 1; A_WE = 0; A_ADDR_R1 = 5'd1; A_ADDR_R2 = 5'd2;
        tick;
        tick;
        tick;
        total++; if (A_ACK !== 1'b1) begin bad++; $display("FAIL sim_rb_ack: got %b want 1", A_ACK); end
        total++; if ({RDATA1, RDATA2} !== {32'h11, 32'h22}) begin bad++; $display("FAIL sim_readback: got %h %h want 11 22", RDATA1, RDATA2); end
        A_REQ = 0;
        tick;
    endtask

    task test_reset_midop;
        A_REQ = 1; A_WE = 0; A_ADDR_R1 = 5'd5; A_ADDR_R2 = 5'd1;
        tick;
        tick;
        total++; if ({RF_READ, BUSY, A_ACK} !== 3'b110) begin bad++; $display("FAIL rst_pre_capture: got %b want 110", {RF_READ, BUSY, A_ACK}); end
        RST = 1'b1;
        #1;
        total++; if (outs !== '0) begin bad++; $display("FAIL rst_async_clear: got %h want 0", outs); end
        tick;
        RST = 1'b0;
        total++; if (outs !== '0) begin bad++; $display("FAIL rst_held_clear: got %h want 0", outs); end
        tick;
        total++; if ({A_ACK, RF_READ, A_GNT} !== 3'b011) begin bad++; $display("FAIL rst_restart_issue: got %b want 011", {A_ACK, RF_READ, A_GNT}); end
        tick;
        total++; if (A_ACK !== 1'b0) begin bad++; $display("FAIL rst_restart_capture: got %b want 0", A_ACK); end
        tick;
        total++; if (A_ACK !== 1'b1) begin bad++; $display("FAIL rst_restart_ack: got %b want 1", A_ACK); end
        total++; if ({RDATA1, RDATA2} !== {32'hDEADBEEF, 32'h11}) begin bad++; $display("FAIL rst_restart_data: got %h %h want deadbeef 11", RDATA1, RDATA2); end
        A_REQ = 0;
        tick;
    endtask

    task test_fairness;
        logic seq [10];
        int n;
        reset_pulse;
        n = 0;
        A_REQ = 1; A_WE = 1; A_ADDR_W = 5'd3; A_WDATA = 32'h5A5A0003;
        B_REQ = 1; B_WE = 0; B_ADDR_R1 = 5'd3; B_ADDR_R2 = 5'd0;
        for (int c = 0; c < 120 && n < 10; c++) begin
            tick;
            if (A_ACK || B_ACK) begin
                total++; if (A_ACK && B_ACK) begin bad++; $display("FAIL fair_dual_ack: got A=%b B=%b want one", A_ACK, B_ACK); end
                if (B_ACK) begin
                    total++; if (RDATA1 !== 32'h5A5A0003) begin bad++; $display("FAIL fair_b_read: got %h want 5a5a0003", RDATA1); end
                end
                seq[n] = B_ACK;
                n++;
            end
        end
        A_REQ = 0; B_REQ = 0;
        total++; if (n != 10) begin bad++; $display("FAIL fair_timeout: got %0d acks want 10", n); end
        for (int i = 0; i < n; i++) begin
            total++; if (seq[i] !== i[0]) begin bad++; $display("FAIL fair_order_%0d: got B=%b want B=%b", i, seq[i], i[0]); end
        end
        tick;
    endtask

    task test_r0_protect;
        B_REQ = 1; B_WE = 1; B_ADDR_W = 5'd0; B_WDATA = 32'hFFFFFFFF;
        tick;
        total++; if ({RF_WRITE, RF_READ, B_GNT, BUSY} !== 4'b0011) begin bad++; $display("FAIL r0_issue: got %b want 0011", {RF_WRITE, RF_READ, B_GNT, BUSY}); end
        tick;
        total++; if ({B_ACK, A_ACK, RF_WRITE} !== 3'b100) begin bad++; $display("FAIL r0_ack: got %b want 100", {B_ACK, A_ACK, RF_WRITE}); end
        B_REQ = 0;
        tick;
        A_REQ = 1; A_WE = 0; A_ADDR_R1 = 5'd0; A_ADDR_R2 = 5'd0;
        tick;
        tick;
        tick;
        total++; if (A_ACK !== 1'b1) begin bad++; $display("FAIL r0_rb_ack: got %b want 1", A_ACK); end
        total++; if ({RDATA1, RDATA2} !== 64'h0) begin bad++; $display("FAIL r0_readback: got %h %h want 0 0", RDATA1, RDATA2); end
        A_REQ = 0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_single_read;
        test_simultaneous;
        test_reset_midop;
        test_fairness;
        test_r0_protect;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
